// File: rtl/mac_sequencer_if.sv
// mac_sequencer_if -- command/term handshake and MAC control bundle.
//   master : command source / operand feeder (drives CMD_*, TERM_VALID, ABORT)
//   slave  : mac_sequencer (drives CMD_READY, TERM_READY, OP_MODE, Z_SEL,
//            CE_P, BUSY, DONE, TERM_CNT)
interface mac_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             CMD_VALID;
    logic             CMD_READY;
    logic [CNT_W-1:0] CMD_LEN;
    logic             CMD_SRC;
    logic             CMD_CLR;
    logic             TERM_VALID;
    logic             TERM_READY;
    logic             ABORT;
    logic [3:0]       OP_MODE;
    logic             Z_SEL;
    logic             CE_P;
    logic             BUSY;
    logic             DONE;
    logic [CNT_W-1:0] TERM_CNT;

    modport master (
        output CMD_VALID, CMD_LEN, CMD_SRC, CMD_CLR, TERM_VALID, ABORT,
        input  CMD_READY, TERM_READY, OP_MODE, Z_SEL, CE_P, BUSY, DONE, TERM_CNT
    );

    modport slave (
        input  CMD_VALID, CMD_LEN, CMD_SRC, CMD_CLR, TERM_VALID, ABORT,
        output CMD_READY, TERM_READY, OP_MODE, Z_SEL, CE_P, BUSY, DONE, TERM_CNT
    );
endinterface

// File: rtl/mac_sequencer.sv
// mac_sequencer -- sequences a DSP-style MAC slice through CMD_LEN product
// terms, then waits PIPE_LAT cycles for P to settle before pulsing DONE.
//   CLK, RST_N : clock, asynchronous active-low reset
//   bus        : mac_sequencer_if.slave (command accept, term issue,
//                X-mux/Z-mux/CE_P control, BUSY/DONE/TERM_CNT status)
module mac_sequencer #(
    parameter int CNT_W    = 8,
    parameter int PIPE_LAT = 2
) (
    input  logic            CLK,
    input  logic            RST_N,
    mac_sequencer_if.slave  bus
);
    localparam int DW = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [DW-1:0] DRAIN_INIT = DW'(PIPE_LAT - 1);

    localparam logic [3:0] OPM_ZERO = 4'b0000;
    localparam logic [3:0] OPM_M    = 4'b0101;
    localparam logic [3:0] OPM_AB   = 4'b0011;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_FIN} state_t;

    state_t           r_state, w_next;
    logic             r_init;         // holds off CMD_READY until the first edge out of reset
    logic [CNT_W-1:0] r_len;
    logic             r_src;
    logic             r_clr;
    logic [CNT_W-1:0] r_term_cnt;
    logic [DW-1:0]    r_drain_cnt;

    logic             w_accept, w_issue, w_abort, w_last, w_drain_done;
    logic [CNT_W:0]   w_cnt_inc;      // one bit wider so LEN = 2^CNT_W-1 compares without wrap

    logic             w_cmd_ready, w_term_ready, w_z_sel, w_ce_p, w_busy, w_done;
    logic [3:0]       w_op_mode;

    assign w_accept     = (r_state == S_IDLE) && r_init && bus.CMD_VALID;
    assign w_abort      = bus.ABORT && (r_state != S_IDLE);
    assign w_issue      = (r_state == S_ISSUE) && bus.TERM_VALID && !bus.ABORT;
    assign w_cnt_inc    = {1'b0, r_term_cnt} + (CNT_W+1)'(1);
    assign w_last       = (w_cnt_inc == {1'b0, r_len});
    // Drain counter is loaded with PIPE_LAT-1 and FIN follows once its
    // decremented value would reach zero.
    assign w_drain_done = (r_drain_cnt <= DW'(1));

    // State register
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (w_accept) w_next = (bus.CMD_LEN == '0) ? S_FIN : S_ISSUE;
                S_ISSUE: if (w_issue && w_last) w_next = S_DRAIN;
                S_DRAIN: if (w_drain_done) w_next = S_FIN;
                S_FIN:   w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // Command latch, term counter, drain counter
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_init      <= 1'b0;
            r_len       <= '0;
            r_src       <= 1'b0;
            r_clr       <= 1'b0;
            r_term_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_init <= 1'b1;
            if (w_accept) begin
                r_len      <= bus.CMD_LEN;
                r_src      <= bus.CMD_SRC;
                r_clr      <= bus.CMD_CLR;
                r_term_cnt <= '0;
            end else if (w_abort) begin
                r_term_cnt <= '0;
            end else if (w_issue) begin
                r_term_cnt <= w_cnt_inc[CNT_W-1:0];
            end

            if (w_issue && w_last)
                r_drain_cnt <= DRAIN_INIT;
            else if (r_state == S_DRAIN && r_drain_cnt != '0)
                r_drain_cnt <= r_drain_cnt - DW'(1);
        end
    end

    // Output logic: datapath controls follow state, TERM_VALID and ABORT
    always_comb begin
        w_term_ready = 1'b0;
        w_op_mode    = OPM_ZERO;
        w_ce_p       = 1'b0;
        w_z_sel      = 1'b0;
        if (r_state == S_ISSUE) begin
            w_term_ready = !bus.ABORT;
            w_z_sel      = 1'b1;           // stall: feed P back so it holds
            if (w_issue) begin
                w_op_mode = r_src ? OPM_AB : OPM_M;
                w_ce_p    = 1'b1;
                // only the first term of a clearing command starts from zero
                w_z_sel   = !(r_clr && r_term_cnt == '0);
            end
        end
        w_cmd_ready = (r_state == S_IDLE) && r_init;
        w_busy      = (r_state != S_IDLE);
        w_done      = (r_state == S_FIN);
    end

    assign bus.CMD_READY  = w_cmd_ready;
    assign bus.TERM_READY = w_term_ready;
    assign bus.OP_MODE    = w_op_mode;
    assign bus.Z_SEL      = w_z_sel;
    assign bus.CE_P       = w_ce_p;
    assign bus.BUSY       = w_busy;
    assign bus.DONE       = w_done;
    assign bus.TERM_CNT   = r_term_cnt;
endmodule

// File: tb/tb_mac_sequencer.sv
module tb_mac_sequencer;
    logic CLK;
    logic RST_N;
    int   n_tests = 0;
    int   n_fail  = 0;

    mac_sequencer_if #(.CNT_W(8)) bus0 ();
    mac_sequencer_if #(.CNT_W(4)) bus1 ();

    mac_sequencer #(.CNT_W(8), .PIPE_LAT(2)) u_dut0 (.CLK(CLK), .RST_N(RST_N), .bus(bus0));
    mac_sequencer #(.CNT_W(4), .PIPE_LAT(2)) u_dut1 (.CLK(CLK), .RST_N(RST_N), .bus(bus1));

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // datapath controls of DUT0 in one shot: OP_MODE, Z_SEL, CE_P, TERM_READY
    task automatic chk_dp(input string tag, input logic [3:0] op, input logic z,
                          input logic ce, input logic tr);
        chk({tag, ".op"}, 32'(bus0.OP_MODE), 32'(op));
        chk({tag, ".z"},  32'(bus0.Z_SEL), 32'(z));
        chk({tag, ".ce"}, 32'(bus0.CE_P), 32'(ce));
        chk({tag, ".tr"}, 32'(bus0.TERM_READY), 32'(tr));
    endtask

    task automatic chk_rst0(input string tag);
        chk_dp(tag, 4'b0000, 1'b0, 1'b0, 1'b0);
        chk({tag, ".busy"}, 32'(bus0.BUSY), 32'd0);
        chk({tag, ".done"}, 32'(bus0.DONE), 32'd0);
        chk({tag, ".cnt"},  32'(bus0.TERM_CNT), 32'd0);
    endtask

    initial begin : stim
        int seen_done, issues, wraps;
        logic [3:0] prev_cnt;
        RST_N = 1'b0;
        bus0.CMD_VALID = 0; bus0.CMD_LEN = '0; bus0.CMD_SRC = 0; bus0.CMD_CLR = 0;
        bus0.TERM_VALID = 0; bus0.ABORT = 0;
        bus1.CMD_VALID = 0; bus1.CMD_LEN = '0; bus1.CMD_SRC = 0; bus1.CMD_CLR = 0;
        bus1.TERM_VALID = 0; bus1.ABORT = 0;

        // ---- reset ----
        #3;
        chk_rst0("rst");
        chk("rst.rdy", 32'(bus0.CMD_READY), 32'd0);
        @(posedge CLK); #2;
        RST_N = 1'b1;
        #1;
        chk("rst.rdy_pre_edge", 32'(bus0.CMD_READY), 32'd0);
        tick();
        chk("rst.rdy_post_edge", 32'(bus0.CMD_READY), 32'd1);

        // ---- LEN=3, SRC=1, CLR=1, TERM_VALID held ----
        bus0.CMD_VALID = 1; bus0.CMD_LEN = 8'd3; bus0.CMD_SRC = 1; bus0.CMD_CLR = 1;
        bus0.TERM_VALID = 1;
        #1;
        chk_dp("t1.idle", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick(); bus0.CMD_VALID = 0; #1;
        chk_dp("t1.c1", 4'b0011, 1'b0, 1'b1, 1'b1);
        chk("t1.c1.busy", 32'(bus0.BUSY), 32'd1);
        chk("t1.c1.rdy", 32'(bus0.CMD_READY), 32'd0);
        tick();
        // command inputs must be ignored mid-command
        bus0.CMD_VALID = 1; bus0.CMD_LEN = 8'd1; bus0.CMD_SRC = 0; bus0.CMD_CLR = 1; #1;
        chk_dp("t1.c2", 4'b0011, 1'b1, 1'b1, 1'b1);
        chk("t1.c2.cnt", 32'(bus0.TERM_CNT), 32'd1);
        tick(); bus0.CMD_VALID = 0; #1;
        chk_dp("t1.c3", 4'b0011, 1'b1, 1'b1, 1'b1);
        chk("t1.c3.cnt", 32'(bus0.TERM_CNT), 32'd2);
        tick();
        chk_dp("t1.drain", 4'b0000, 1'b0, 1'b0, 1'b0);
        chk("t1.drain.cnt", 32'(bus0.TERM_CNT), 32'd3);
        chk("t1.drain.done", 32'(bus0.DONE), 32'd0);
        tick();
        chk("t1.fin.done", 32'(bus0.DONE), 32'd1);
        chk("t1.fin.busy", 32'(bus0.BUSY), 32'd1);
        chk("t1.fin.rdy", 32'(bus0.CMD_READY), 32'd0);
        tick();
        chk("t1.idle.done", 32'(bus0.DONE), 32'd0);
        chk("t1.idle.busy", 32'(bus0.BUSY), 32'd0);
        chk("t1.idle.rdy", 32'(bus0.CMD_READY), 32'd1);

        // ---- LEN=2, SRC=0, CLR=0, TERM_VALID 1,0,0,1 ----
        bus0.CMD_VALID = 1; bus0.CMD_LEN = 8'd2; bus0.CMD_SRC = 0; bus0.CMD_CLR = 0;
        bus0.TERM_VALID = 1;
        tick(); bus0.CMD_VALID = 0; #1;
        chk_dp("t2.c1", 4'b0101, 1'b1, 1'b1, 1'b1);
        tick(); bus0.TERM_VALID = 0; #1;
        chk("t2.c2.cnt", 32'(bus0.TERM_CNT), 32'd1);
        chk_dp("t2.c2", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick();
        chk("t2.c3.cnt", 32'(bus0.TERM_CNT), 32'd1);
        chk_dp("t2.c3", 4'b0000, 1'b1, 1'b0, 1'b1);
        tick(); bus0.TERM_VALID = 1; #1;
        chk("t2.c4.cnt", 32'(bus0.TERM_CNT), 32'd1);
        chk_dp("t2.c4", 4'b0101, 1'b1, 1'b1, 1'b1);
        tick(); bus0.TERM_VALID = 0; #1;
        chk("t2.drain.cnt", 32'(bus0.TERM_CNT), 32'd2);
        chk_dp("t2.drain", 4'b0000, 1'b0, 1'b0, 1'b0);
        tick();
        chk("t2.fin.done", 32'(bus0.DONE), 32'd1);
        tick();

        // ---- LEN=0 ----
        bus0.CMD_VALID = 1; bus0.CMD_LEN = 8'd0; bus0.TERM_VALID = 1;
        tick(); bus0.CMD_VALID = 0; #1;
        chk("t3.fin.done", 32'(bus0.DONE), 32'd1);
        chk("t3.fin.busy", 32'(bus0.BUSY), 32'd1);
        chk("t3.fin.ce", 32'(bus0.CE_P), 32'd0);
        tick();
        chk("t3.idle.done", 32'(bus0.DONE), 32'd0);
        chk("t3.idle.busy", 32'(bus0.BUSY), 32'd0);

        // ---- ABORT on 2nd issue cycle of LEN=4 ----
        bus0.CMD_VALID = 1; bus0.CMD_LEN = 8'd4; bus0.CMD_SRC = 1; bus0.CMD_CLR = 1;
        bus0.TERM_VALID = 1;
        tick(); bus0.CMD_VALID = 0; #1;
        chk("t4.c1.ce", 32'(bus0.CE_P), 32'd1);
        tick(); bus0.ABORT = 1; #1;
        chk_dp("t4.abort", 4'b0000, 1'b1, 1'b0, 1'b0);
        tick(); bus0.ABORT = 0; bus0.TERM_VALID = 0; #1;
        chk("t4.post.busy", 32'(bus0.BUSY), 32'd0);
        chk("t4.post.cnt", 32'(bus0.TERM_CNT), 32'd0);
        chk("t4.post.rdy", 32'(bus0.CMD_READY), 32'd1);
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            if (bus0.DONE) seen_done++;
            tick();
        end
        chk("t4.no_done", 32'(seen_done), 32'd0);

        // ---- ABORT in IDLE with CMD_VALID still accepts ----
        bus0.CMD_VALID = 1; bus0.CMD_LEN = 8'd1; bus0.CMD_SRC = 0; bus0.CMD_CLR = 1;
        bus0.ABORT = 1; bus0.TERM_VALID = 1;
        tick(); bus0.CMD_VALID = 0; bus0.ABORT = 0; #1;
        chk("t5.busy", 32'(bus0.BUSY), 32'd1);
        chk_dp("t5.issue", 4'b0101, 1'b0, 1'b1, 1'b1);
        tick();
        chk("t5.drain.busy", 32'(bus0.BUSY), 32'd1);
        tick();
        chk("t5.fin.done", 32'(bus0.DONE), 32'd1);
        tick();

        // ---- reset during DRAIN ----
        bus0.CMD_VALID = 1; bus0.CMD_LEN = 8'd1; bus0.CMD_SRC = 1; bus0.CMD_CLR = 0;
        bus0.TERM_VALID = 1;
        tick(); bus0.CMD_VALID = 0; #1;
        tick(); bus0.TERM_VALID = 0; #1;
        chk("t6.drain.cnt", 32'(bus0.TERM_CNT), 32'd1);
        RST_N = 1'b0;
        #1;
        chk_rst0("t6.rst");
        chk("t6.rst.rdy", 32'(bus0.CMD_READY), 32'd0);
        #2;
        RST_N = 1'b1;
        seen_done = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (bus0.DONE) seen_done++;
        end
        chk("t6.no_done", 32'(seen_done), 32'd0);
        chk("t6.rdy", 32'(bus0.CMD_READY), 32'd1);

        // ---- CNT_W=4, LEN=15 ----
        bus1.CMD_VALID = 1; bus1.CMD_LEN = 4'd15; bus1.CMD_SRC = 0; bus1.CMD_CLR = 1;
        bus1.TERM_VALID = 1;
        tick(); bus1.CMD_VALID = 0; #1;
        issues = 0; seen_done = 0; wraps = 0; prev_cnt = 4'd0;
        for (int i = 0; i < 25; i++) begin
            if (bus1.CE_P) issues++;
            if (bus1.DONE) seen_done++;
            if (bus1.TERM_CNT < prev_cnt) wraps++;
            prev_cnt = bus1.TERM_CNT;
            tick();
        end
        chk("t7.issues", 32'(issues), 32'd15);
        chk("t7.done", 32'(seen_done), 32'd1);
        chk("t7.wrap", 32'(wraps), 32'd0);
        chk("t7.cnt", 32'(bus1.TERM_CNT), 32'd15);
        chk("t7.busy", 32'(bus1.BUSY), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/mac_sequencer.md
MAC_SEQUENCER -- requirements
Module: mac_sequencer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of term-count fields.
REQ-002 SHALL have parameter PIPE_LAT, default 2, cycles from term issue to P stable at the slice output.
REQ-003 SHALL have port CLK  input  1  the only clock; all state updates on rising edge.
REQ-004 SHALL have port RST_N  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port CMD_VALID  input  1  command request.
REQ-006 SHALL have port CMD_READY  output  1  command accept; a command transfers on CMD_VALID & CMD_READY.
REQ-007 SHALL have port CMD_LEN  input  CNT_W  number of product terms.
REQ-008 SHALL have port CMD_SRC  input  1  term source: 0 = M, 1 = {A,B}.
REQ-009 SHALL have port CMD_CLR  input  1  1 = first term starts from zero; 0 = accumulate onto existing P.
REQ-010 SHALL have port TERM_VALID  input  1  operands for the next term are on the datapath.
REQ-011 SHALL have port TERM_READY  output  1  a term issues on TERM_VALID & TERM_READY.
REQ-012 SHALL have port ABORT  input  1  synchronous cancel of the current command.
REQ-013 SHALL have port OP_MODE  output  4  X-mux select: 0000 = zero, 0101 = M, 0011 = {A,B}.
REQ-014 SHALL have port Z_SEL  output  1  0 = Z operand zero; 1 = Z = P feedback.
REQ-015 SHALL have port CE_P  output  1  P register clock enable.
REQ-016 SHALL have port BUSY  output  1  high in every state except IDLE.
REQ-017 SHALL have port DONE  output  1  one-cycle completion pulse.
REQ-018 SHALL have port TERM_CNT  output  CNT_W  terms issued in the current command.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN and FIN.
REQ-020 IDLE: CMD_READY=1; on transfer, SHALL latch LEN, SRC and CLR, clear TERM_CNT, and go to ISSUE, or to FIN if CMD_LEN=0.
REQ-021 ISSUE: TERM_READY=1 and CMD_READY=0.
- Issue cycle: OP_MODE = 0101 if SRC=0, else 0011; CE_P=1; TERM_CNT increments.
- Z_SEL=0 only on the first term of a command with CLR=1; otherwise 1.
REQ-022 ISSUE with TERM_VALID=0: OP_MODE=0000, CE_P=0, Z_SEL=1 (P holds); no timeout.
REQ-023 On the issue cycle where TERM_CNT+1 == LEN, SHALL go to DRAIN and load a drain counter with PIPE_LAT-1.
REQ-024 DRAIN: OP_MODE=0000, CE_P=0, TERM_READY=0; decrements each cycle; at 0 goes to FIN.
REQ-025 FIN: DONE=1 for exactly one cycle; next state IDLE; CMD_READY=0 in FIN.
REQ-026 Back-to-back commands: minimum turnaround is one IDLE cycle after FIN.
REQ-027 OP_MODE, Z_SEL, CE_P and TERM_READY SHALL be combinational from state and TERM_VALID; all other outputs SHALL be registered or derived from state only.
REQ-028 ABORT=1 in ISSUE, DRAIN or FIN: next state IDLE, no DONE pulse, TERM_CNT cleared.
- Same cycle: TERM_READY=0, CE_P=0, OP_MODE=0000.
- ABORT takes priority over a concurrent term handshake.
REQ-029 ABORT in IDLE SHALL be ignored; ABORT with CMD_VALID in IDLE still accepts the command.
REQ-030 CMD_LEN = 2^CNT_W-1 SHALL complete normally; TERM_CNT SHALL never wrap within a command.
REQ-031 SHALL ignore CMD_* inputs outside IDLE; latched values SHALL be stable for the whole command.

Reset
REQ-032 RST_N=0 SHALL immediately force state IDLE and set TERM_CNT=0, DONE=0, BUSY=0, CE_P=0, Z_SEL=0, OP_MODE=0000, TERM_READY=0.
- CMD_READY SHALL rise on the first rising edge after RST_N deasserts.
REQ-033 Reset mid-command SHALL drop the command with no DONE pulse.

Verification
REQ-034 SHALL check: LEN=3, SRC=1, CLR=1, TERM_VALID held 1 -> OP_MODE=0011 for 3 cycles, Z_SEL 0,1,1, CE_P 1,1,1, then 1 DRAIN cycle (PIPE_LAT=2), DONE on the 5th cycle after accept.
REQ-035 SHALL check: LEN=2, SRC=0, CLR=0, TERM_VALID 1,0,0,1 -> OP_MODE 0101,0000,0000,0101; Z_SEL always 1; TERM_CNT 1,1,1,2.
REQ-036 SHALL check: LEN=0 -> no CE_P, DONE exactly one cycle after accept, BUSY high for 1 cycle.
REQ-037 SHALL check: ABORT on the 2nd issue cycle of LEN=4 with TERM_VALID=1 -> CE_P=0 that cycle, IDLE next, no DONE, TERM_CNT=0.
REQ-038 SHALL check: RST_N low during DRAIN -> all outputs at reset values asynchronously; no DONE after release.
REQ-039 SHALL check: CNT_W=4, LEN=15 -> 15 issues, TERM_CNT reaches 15 without wrap, single DONE.
